// File: rtl/uart_cmd_wrapper.sv
// uart_cmd_wrapper: 8N1 UART endpoint that pairs received bytes into 16-bit commands and sends response bytes.
module uart_cmd_wrapper #(
  parameter int BAUD_DIV = 2604,
  parameter int BYTE_TMO = 2**20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        trmt,
  output logic        tx_done
);
  localparam int BW = $clog2(BAUD_DIV);
  localparam int TW = $clog2(BYTE_TMO + 1);
  localparam logic [BW-1:0] LAST = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] HALF = BW'(BAUD_DIV / 2 - 1);
  localparam logic [TW-1:0] TMO = TW'(BYTE_TMO);
  typedef enum logic {R_IDLE, R_RECV} rx_st_e;
  typedef enum logic {A_HI, A_LO} asm_st_e;
  typedef enum logic {T_IDLE, T_XMIT} tx_st_e;
  rx_st_e         rx_st_q;
  asm_st_e        asm_q;
  tx_st_e         tx_st_q;
  logic [1:0]     rx_ff_q;
  logic [BW-1:0]  rx_baud_q, tx_baud_q;
  logic [3:0]     rx_bit_q, tx_bit_q;
  logic [7:0]     rx_byte_q, cmd_hi_q;
  logic [15:0]    cmd_q;
  logic           cmd_rdy_q, tx_done_q;
  logic [TW-1:0]  tmo_q;
  logic [9:0]     shft_q;
  logic           rx_s, rx_tick, byte_rdy, frm_err, start_det;
  assign rx_s      = rx_ff_q[1];
  // first sample lands mid start bit, the rest one full bit apart
  assign rx_tick   = rx_st_q == R_RECV && rx_baud_q == (rx_bit_q == 4'd0 ? HALF : LAST);
  assign byte_rdy  = rx_tick && rx_bit_q == 4'd9 && rx_s;
  assign frm_err   = rx_tick && rx_bit_q == 4'd9 && !rx_s;
  assign start_det = rx_st_q == R_IDLE && !rx_s;
  assign TX        = shft_q[0];
  assign cmd       = cmd_q;
  assign cmd_rdy   = cmd_rdy_q;
  assign tx_done   = tx_done_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rx_ff_q   <= 2'b11;
      rx_st_q   <= R_IDLE;
      rx_baud_q <= '0;
      rx_bit_q  <= '0;
      rx_byte_q <= '0;
    end else begin
      rx_ff_q <= {rx_ff_q[0], RX};
      if (rx_st_q == R_IDLE) begin
        rx_baud_q <= '0;
        rx_bit_q  <= '0;
        if (start_det) rx_st_q <= R_RECV;
      end else if (rx_tick) begin
        rx_baud_q <= '0;
        rx_bit_q  <= rx_bit_q + 1'b1;
        if ((rx_bit_q == 4'd0 && rx_s) || rx_bit_q == 4'd9) rx_st_q <= R_IDLE;
        if (rx_bit_q != 4'd0 && rx_bit_q != 4'd9) rx_byte_q <= {rx_s, rx_byte_q[7:1]};
      end else
        rx_baud_q <= rx_baud_q + 1'b1;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      asm_q     <= A_HI;
      cmd_hi_q  <= '0;
      cmd_q     <= '0;
      cmd_rdy_q <= 1'b0;
      tmo_q     <= '0;
    end else begin
      if (asm_q == A_HI) begin
        if (byte_rdy) begin
          cmd_hi_q <= rx_byte_q;
          asm_q    <= A_LO;
          tmo_q    <= '0;
        end
      end else if (byte_rdy) begin
        cmd_q <= {cmd_hi_q, rx_byte_q};
        asm_q <= A_HI;
      end else if (frm_err || tmo_q == TMO)
        asm_q <= A_HI;
      else if (rx_st_q == R_IDLE)
        tmo_q <= tmo_q + 1'b1;
      cmd_rdy_q <= (asm_q == A_LO && byte_rdy) ||
                   (cmd_rdy_q && !clr_cmd_rdy && !(asm_q == A_HI && start_det));
    end
  // ones shift in behind the frame so TX rests high once the stop bit is out
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tx_st_q   <= T_IDLE;
      shft_q    <= '1;
      tx_baud_q <= '0;
      tx_bit_q  <= '0;
      tx_done_q <= 1'b0;
    end else if (tx_st_q == T_IDLE) begin
      if (trmt) begin
        shft_q    <= {1'b1, resp, 1'b0};
        tx_st_q   <= T_XMIT;
        tx_done_q <= 1'b0;
        tx_baud_q <= '0;
        tx_bit_q  <= '0;
      end
    end else if (tx_baud_q == LAST) begin
      tx_baud_q <= '0;
      shft_q    <= {1'b1, shft_q[9:1]};
      tx_bit_q  <= tx_bit_q + 1'b1;
      if (tx_bit_q == 4'd9) begin
        tx_st_q   <= T_IDLE;
        tx_done_q <= 1'b1;
      end
    end else
      tx_baud_q <= tx_baud_q + 1'b1;
endmodule
